// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - program word stream between a word source and the loader
interface prog_loader_if #(
    parameter int DW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] in_data;
    logic            in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - program-load initiator for the 4-bit stored-program core (optional PROG_LOADER_PAD_EN)
module prog_loader #(
    parameter int          DW     = 4,
    parameter int          DEPTH  = 16,
    parameter int          AW     = $clog2(DEPTH),
    parameter int unsigned PAD_OP = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    prog_loader_if.slave  s,
    input  logic [DW-1:0] run_portin,
    output logic          PC_reset,
    output logic          mem_write,
    output logic [DW-1:0] instr,
    output logic [DW-1:0] portin,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic [AW:0]   word_count
);
    typedef enum logic [2:0] {IDLE, PCRST, LOAD, PAD, FINISH, RUN} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    if (PAD_OP >= (1 << DW)) begin : g_pad_op_too_wide
        $error("PAD_OP does not fit in DW bits");
    end

    state_t          state, state_d;
    logic            in_ready_q, in_ready_d;
    logic            pc_reset_d, mem_write_d, busy_d, done_d, overflow_d;
    logic [DW-1:0]   instr_d, portin_d;
    logic [AW:0]     word_count_d, wc_inc;
    logic            hs;

    assign s.in_ready = in_ready_q;
    assign hs         = s.in_valid && in_ready_q;
    assign wc_inc     = word_count + (AW+1)'(1);

`ifdef PROG_LOADER_PAD_EN
    logic [AW:0] pad_addr;

    // next unused program address that still needs the pad word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pad_addr <= '0;
        else if (state == LOAD && hs && s.in_last)
            pad_addr <= wc_inc;
        else if (state == PAD)
            pad_addr <= pad_addr + (AW+1)'(1);
    end
`endif

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    // next-state: start only honoured while idle or running
    always_comb begin
        state_d = state;
        case (state)
            IDLE, RUN: if (start) state_d = PCRST;
            PCRST:     state_d = LOAD;
            LOAD: begin
                if (hs && s.in_last) begin
                    state_d = FINISH;
`ifdef PROG_LOADER_PAD_EN
                    if (!overflow && wc_inc < DEPTH_W)
                        state_d = PAD;
`endif
                end
            end
`ifdef PROG_LOADER_PAD_EN
            PAD:       if (pad_addr == DEPTH_W - (AW+1)'(1)) state_d = FINISH;
`endif
            FINISH:    state_d = RUN;
            default:   state_d = IDLE;
        endcase
    end

    // next output values; data outputs hold unless a write or pass-through updates them
    always_comb begin
        pc_reset_d   = 1'b0;
        mem_write_d  = 1'b0;
        in_ready_d   = 1'b0;
        done_d       = 1'b0;
        instr_d      = instr;
        portin_d     = portin;
        word_count_d = word_count;
        overflow_d   = overflow;
        busy_d       = (state_d != IDLE && state_d != RUN) || (state == FINISH);
        case (state)
            IDLE, RUN: begin
                portin_d = run_portin;
                done_d   = (state == RUN) && PC_reset;
                if (start) begin
                    pc_reset_d   = 1'b1;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                end
            end
            PCRST: in_ready_d = 1'b1;
            LOAD: begin
                in_ready_d = 1'b1;
                if (hs) begin
                    if (!overflow) begin
                        mem_write_d  = 1'b1;
                        instr_d      = s.in_data[2*DW-1:DW];
                        portin_d     = s.in_data[DW-1:0];
                        word_count_d = wc_inc;
                        if (!s.in_last && wc_inc == DEPTH_W) begin
                            overflow_d = 1'b1;
                            in_ready_d = 1'b0;
                        end
                    end
                    if (s.in_last)
                        in_ready_d = 1'b0;
                end
            end
`ifdef PROG_LOADER_PAD_EN
            PAD: begin
                mem_write_d = 1'b1;
                instr_d     = DW'(PAD_OP);
                portin_d    = '0;
            end
`endif
            FINISH: pc_reset_d = 1'b1;
            default: ;
        endcase
    end

    // output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            PC_reset   <= 1'b0;
            mem_write  <= 1'b0;
            instr      <= '0;
            portin     <= '0;
            in_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            PC_reset   <= pc_reset_d;
            mem_write  <= mem_write_d;
            instr      <= instr_d;
            portin     <= portin_d;
            in_ready_q <= in_ready_d;
            busy       <= busy_d;
            done       <= done_d;
            overflow   <= overflow_d;
            word_count <= word_count_d;
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader with a core memory model
module tb_prog_loader;
    localparam int DW = 4;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam logic [3:0] PAD_OP = 4'h0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] run_portin = '0;
    logic          PC_reset, mem_write, busy, done, overflow;
    logic [DW-1:0] instr, portin;
    logic [AW:0]   word_count;

    prog_loader_if #(.DW(DW)) sif ();

    prog_loader #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .PAD_OP(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .s(sif), .run_portin(run_portin),
        .PC_reset(PC_reset), .mem_write(mem_write), .instr(instr), .portin(portin),
        .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // model: expected write stream, and the core's memory and PC as it would see the load port
    logic [7:0] prog[$];
    logic [7:0] exp_q[$];
    logic [7:0] core_mem [DEPTH];
    int core_pc = 0;
    int pcrst = 0;
    int writes = 0;
    int bursts = 0;
    logic prev_mw = 1'b0;

    always @(negedge clk) begin
        logic [7:0] e;
        if (reset_n) begin
            if (mem_write) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_instr", int'(instr), int'(e[7:4]));
                    chk("wr_portin", int'(portin), int'(e[3:0]));
                end
                chk("wr_after_one_pcrst", pcrst, 1);
                chk("wr_no_pcrst", int'(PC_reset), 0);
                core_mem[core_pc % DEPTH] = {instr, portin};
                core_pc++;
                writes++;
                if (!prev_mw) bursts++;
            end
            if (PC_reset) begin
                core_pc = 0;
                pcrst++;
            end
            if (done) begin
                chk("done_all_written", exp_q.size(), 0);
                chk("done_pcrst_cycles", pcrst, 2);
            end
            prev_mw = mem_write;
        end else begin
            prev_mw = 1'b0;
        end
    end

    int n_pad_writes;

    task automatic run_load(input bit gap, input int abort_at);
        int n, i, cyc;
        bit idle_slot;
        n = prog.size();
        exp_q.delete();
        for (int k = 0; k < n && k < DEPTH; k++) exp_q.push_back(prog[k]);
`ifdef PROG_LOADER_PAD_EN
        for (int k = n; k < DEPTH; k++) exp_q.push_back({PAD_OP, 4'h0});
`endif
        pcrst = 0;
        writes = 0;
        bursts = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        i = 0;
        cyc = 0;
        idle_slot = 1'b0;
        while (i < n && cyc < 400) begin
            if (abort_at > 0 && i == abort_at) break;
            if (gap && idle_slot) begin
                sif.in_valid = 1'b0;
                start = 1'b1;
                idle_slot = 1'b0;
            end else begin
                start = 1'b0;
                sif.in_valid = 1'b1;
                sif.in_data = prog[i];
                sif.in_last = (i == n - 1);
                if (sif.in_ready) begin
                    i++;
                    idle_slot = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        sif.in_valid = 1'b0;
        sif.in_last = 1'b0;
        start = 1'b0;
        if (cyc >= 400) chk("stream_timeout", 0, 1);
        if (abort_at == 0) begin
            cyc = 0;
            while (!done && cyc < 200) begin
                tick();
                cyc++;
            end
            chk("done_seen", int'(done), 1);
            tick();
            chk("done_pulse_one_cycle", int'(done), 0);
            chk("busy_after_done", int'(busy), 0);
        end
    endtask

    initial begin
        sif.in_valid = 1'b0;
        sif.in_data = '0;
        sif.in_last = 1'b0;
`ifdef PROG_LOADER_PAD_EN
        n_pad_writes = 1;
`else
        n_pad_writes = 0;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pc_reset", int'(PC_reset), 0);
        chk("rst_mem_write", int'(mem_write), 0);
        chk("rst_instr", int'(instr), 0);
        chk("rst_portin", int'(portin), 0);
        chk("rst_in_ready", int'(sif.in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_word_count", int'(word_count), 0);
        reset_n = 1'b1;
        tick();
        chk("idle_in_ready", int'(sif.in_ready), 0);
        chk("idle_busy", int'(busy), 0);
        run_portin = 4'hA;
        tick();
        chk("idle_portin_pass", int'(portin), 'hA);

        // basic 10-word program
        prog = '{8'h63, 8'h40, 8'h63, 8'h41, 8'h50, 8'h80, 8'h51, 8'h00, 8'h70, 8'h99};
        run_load(1'b0, 0);
        chk("basic_word_count", int'(word_count), 10);
        chk("basic_overflow", int'(overflow), 0);
        chk("basic_bursts", bursts, 1);
        chk("basic_writes", writes, n_pad_writes ? 16 : 10);
        chk("basic_core_mem0", int'(core_mem[0]), 'h63);
        chk("basic_core_mem9", int'(core_mem[9]), 'h99);
        run_portin = 4'h5;
        tick();
        chk("run_portin_pass", int'(portin), 5);

        // stalled stream with start pokes during the load
        prog = '{8'hA1, 8'hB2, 8'hC3};
        run_load(1'b1, 0);
        chk("stall_word_count", int'(word_count), 3);
        chk("stall_bursts", bursts, 3);
        chk("stall_writes", writes, n_pad_writes ? 16 : 3);
        chk("stall_core_mem2", int'(core_mem[2]), 'hC3);

        // overflow: 18 words offered
        prog.delete();
        for (int k = 0; k < 18; k++) prog.push_back(8'(k * 17));
        run_load(1'b0, 0);
        chk("ovf_word_count", int'(word_count), 16);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_writes", writes, 16);
        chk("ovf_core_mem15", int'(core_mem[15]), 'hFF);
        chk("ovf_core_mem0", int'(core_mem[0]), 'h00);

        // short program: padding or stale tail
        prog = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        run_load(1'b0, 0);
        chk("pad_overflow_cleared", int'(overflow), 0);
        chk("pad_word_count", int'(word_count), 5);
        chk("pad_writes", writes, n_pad_writes ? 16 : 5);
        chk("pad_core_mem4", int'(core_mem[4]), 'h9A);
        chk("pad_core_mem5", int'(core_mem[5]), n_pad_writes ? 0 : 'h55);
        chk("pad_core_mem15", int'(core_mem[15]), n_pad_writes ? 0 : 'hFF);

        // asynchronous reset after 4 writes
        prog = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        run_load(1'b0, 4);
        chk("abort_writes", writes, 4);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_mem_write", int'(mem_write), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_word_count", int'(word_count), 0);
        chk("abort_in_ready", int'(sif.in_ready), 0);
        chk("abort_pc_reset", int'(PC_reset), 0);
        tick();
        reset_n = 1'b1;
        tick();
        prog = '{8'h3C, 8'h4D, 8'h5E};
        run_load(1'b0, 0);
        chk("reload_word_count", int'(word_count), 3);
        chk("reload_core_mem0", int'(core_mem[0]), 'h3C);
        chk("reload_core_mem2", int'(core_mem[2]), 'h5E);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
